// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, FSM encoding, fetch pair.
// Optional feature macro used by the stage: IF_MISALIGN_CHK_EN.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [`WORD_LEN-1:0] PC_STEP = `WORD_LEN'd4;

    typedef struct packed {
        logic [`WORD_LEN-1:0] pc;
        logic [`WORD_LEN-1:0] instr;
    } fetch_pair_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched instruction and its PC+4 while IF/ID is frozen.
// Flush wins over load so a redirect can never leave stale data behind.
module if_skid_buf
    import if_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_flush,
    input  fetch_pair_t i_pair,
    output logic        o_valid,
    output fetch_pair_t o_pair
);

    logic        r_valid;
    fetch_pair_t r_pair;

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_valid <= 1'b0;
            r_pair  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pair  <= i_pair;
        end
    end

    assign o_valid = r_valid;
    assign o_pair  = r_pair;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues word fetches, absorbs IF/ID freezes and redirects on branches.
// Define IF_MISALIGN_CHK_EN to force-align branch targets and flag misalignment (sticky).
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [`WORD_LEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 branch_taken,
    input  logic [`WORD_LEN-1:0] branch_addr,
    output logic                 imem_req,
    output logic [`WORD_LEN-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [`WORD_LEN-1:0] imem_rdata,
    output logic [`WORD_LEN-1:0] PC,
    output logic [`WORD_LEN-1:0] instruction,
    output logic                 fetch_valid,
    output logic                 misalign_err
);

    fetch_state_e         r_state, w_state_nxt;
    logic [`WORD_LEN-1:0] r_pc_q, r_drain_addr, r_pc_out, r_instr;
    logic                 r_valid;
    logic [`WORD_LEN-1:0] w_pc_inc, w_br_tgt;
    logic                 w_skid_load, w_skid_flush, w_skid_valid;
    fetch_pair_t          w_skid_in, w_skid_out;

    assign w_pc_inc = r_pc_q + PC_STEP;

`ifdef IF_MISALIGN_CHK_EN
    logic r_misalign;

    assign w_br_tgt = {branch_addr[`WORD_LEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst)
            r_misalign <= 1'b0;
        else if (branch_taken && (branch_addr[1:0] != 2'b00))
            r_misalign <= 1'b1;
    end

    assign misalign_err = r_misalign;
`else
    assign w_br_tgt     = branch_addr;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_skid_load  = 1'b0;
        w_skid_flush = branch_taken;
        case (r_state)
            ST_FETCH: begin
                if (branch_taken)
                    w_state_nxt = imem_ack ? ST_FETCH : ST_DRAIN;
                else if (imem_ack && freeze) begin
                    w_state_nxt = ST_HOLD;
                    w_skid_load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (branch_taken || !freeze) begin
                    w_state_nxt  = ST_FETCH;
                    w_skid_flush = 1'b1;
                end
            end
            // The old request must complete before the target can be issued.
            ST_DRAIN: if (imem_ack) w_state_nxt = ST_FETCH;
            default:  w_state_nxt = ST_FETCH;
        endcase
    end

    assign w_skid_in.pc    = w_pc_inc;
    assign w_skid_in.instr = imem_rdata;

    if_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_flush (w_skid_flush),
        .i_pair  (w_skid_in),
        .o_valid (w_skid_valid),
        .o_pair  (w_skid_out)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_FETCH;
            r_pc_q       <= RESET_PC;
            r_drain_addr <= '0;
            r_pc_out     <= '0;
            r_instr      <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (branch_taken) begin
                r_pc_q   <= w_br_tgt;
                r_pc_out <= '0;
                r_instr  <= '0;
                r_valid  <= 1'b0;
                if (r_state == ST_FETCH)
                    r_drain_addr <= r_pc_q;
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        if (imem_ack) begin
                            r_pc_q <= w_pc_inc;
                            if (!freeze) begin
                                r_pc_out <= w_pc_inc;
                                r_instr  <= imem_rdata;
                                r_valid  <= 1'b1;
                            end
                        end else if (!freeze) begin
                            r_pc_out <= '0;
                            r_instr  <= '0;
                            r_valid  <= 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        if (!freeze) begin
                            r_pc_out <= w_skid_out.pc;
                            r_instr  <= w_skid_out.instr;
                            r_valid  <= w_skid_valid;
                        end
                    end
                    ST_DRAIN: begin
                        if (!freeze) begin
                            r_pc_out <= '0;
                            r_instr  <= '0;
                            r_valid  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_req    = rst && (r_state != ST_HOLD);
    assign imem_addr   = (r_state == ST_DRAIN) ? r_drain_addr : r_pc_q;
    assign PC          = r_pc_out;
    assign instruction = r_instr;
    assign fetch_valid = r_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a memory responder pushes expected fetch pairs,
// which are popped when the IF/ID register (freeze=0) would capture a valid output.
module tb_if_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk, rst, freeze, branch_taken, imem_req, imem_ack, fetch_valid, misalign_err;
    logic [31:0] branch_addr, imem_addr, imem_rdata, PC, instruction;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    bit          draining;
    int          n_vec, n_err;

    if_fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .PC           (PC),
        .instruction  (instruction),
        .fetch_valid  (fetch_valid),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] f_tgt(input logic [31:0] a);
`ifdef IF_MISALIGN_CHK_EN
        return {a[31:2], 2'b00};
`else
        return a;
`endif
    endfunction

    // One clock: drive at negedge, memory acks a live request if ack_en, then the edge.
    task automatic cyc(input bit frz, input bit br, input logic [31:0] ba, input bit ack_en);
        exp_t e;
        @(negedge clk);
        freeze       = frz;
        branch_taken = br;
        branch_addr  = ba;
        imem_ack     = imem_req && ack_en;
        imem_rdata   = imem_addr ^ KEY;
        if (!frz && fetch_valid) begin
            if (sb.size() == 0)
                chk("sb_underflow", fetch_valid, 1'b0);
            else begin
                e = sb.pop_front();
                chk("out_pc", PC, e.pc);
                chk("out_ins", instruction, e.ins);
            end
        end
        if (imem_ack) begin
            if (draining)
                draining = 1'b0;
            else if (!br) begin
                chk("fetch_addr", imem_addr, m_pc);
                e.pc  = m_pc + 32'd4;
                e.ins = m_pc ^ KEY;
                sb.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        if (br) begin
            sb.delete();
            if (imem_req && !imem_ack) draining = 1'b1;
            m_pc = f_tgt(ba);
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", PC, 32'h0);
        chk("rst_ins", instruction, 32'h0);
        chk("rst_valid", fetch_valid, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_err", misalign_err, 1'b0);
        rst = 1'b1;
        sb.delete();
        draining = 1'b0;
        m_pc = 32'h0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        imem_ack = 1'b0; imem_rdata = '0; m_pc = '0; draining = 1'b0;
        do_reset();

        // Streaming: PC 4, 8 appear with matching data.
        cyc(0, 0, 0, 1); #1 chk("stream_pc4", PC, 32'd4);
        cyc(0, 0, 0, 1); #1 chk("stream_pc8", PC, 32'd8);
        // Freeze with ack at pc_q=8: PC=8 pair held, then PC=12 after release.
        cyc(1, 0, 0, 1); #1 chk("frz_hold0", PC, 32'd8);
        cyc(1, 0, 0, 1); #1 chk("frz_hold1", PC, 32'd8);
        chk("hold_noreq", imem_req, 1'b0);
        cyc(1, 0, 0, 1); #1 chk("frz_hold2", fetch_valid, 1'b1);
        cyc(0, 0, 0, 1); #1 chk("frz_rel_pc", PC, 32'd12);
        chk("frz_rel_ins", instruction, 32'd8 ^ KEY);
        // Branch while request to 0x10 is outstanding.
        cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h100, 0); #1 chk("drain_addr", imem_addr, 32'h10);
        chk("drain_req", imem_req, 1'b1);
        chk("drain_bubble", fetch_valid, 1'b0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1); #1 chk("post_drain_addr", imem_addr, 32'h100);
        cyc(0, 0, 0, 1); #1 chk("tgt_pc", PC, 32'h104);
        // Two branches during one drain: last target wins.
        cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h200, 0);
        cyc(0, 1, 32'h300, 0); #1 chk("drain2_addr", imem_addr, 32'h108);
        cyc(0, 0, 0, 1); #1 chk("last_tgt", imem_addr, 32'h300);
        cyc(0, 0, 0, 1);
        // Branch, freeze and ack together.
        cyc(1, 1, 32'h100, 1); #1 chk("bfa_addr", imem_addr, 32'h100);
        chk("bfa_valid", fetch_valid, 1'b0);
        chk("bfa_pc", PC, 32'h0);
        chk("bfa_ins", instruction, 32'h0);
        // Branch while in HOLD discards the skid entry.
        cyc(1, 0, 0, 1);
        cyc(1, 1, 32'h400, 0); #1 chk("holdbr_addr", imem_addr, 32'h400);
        chk("holdbr_valid", fetch_valid, 1'b0);
        cyc(0, 0, 0, 1);
        // PC+4 wraps at the top of the address space.
        cyc(0, 1, 32'hFFFF_FFFC, 1);
        cyc(0, 0, 0, 1); #1 chk("wrap_pc", PC, 32'h0);
        cyc(0, 0, 0, 1);
        // Misaligned branch target.
        cyc(0, 1, 32'h102, 1);
`ifdef IF_MISALIGN_CHK_EN
        #1 chk("mis_addr", imem_addr, 32'h100);
        chk("mis_err", misalign_err, 1'b1);
`else
        #1 chk("mis_addr", imem_addr, 32'h102);
        chk("mis_err", misalign_err, 1'b0);
`endif
        cyc(0, 0, 0, 1);
        // Reset asserted mid-HOLD.
        cyc(1, 0, 0, 1);
`ifdef IF_MISALIGN_CHK_EN
        #1 chk("mis_sticky", misalign_err, 1'b1);
`endif
        do_reset();
        cyc(0, 0, 0, 1); #1 chk("post_rst_pc", PC, 32'd4);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, a, $urandom_range(0, 9) < 6);
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(0, 0, 0, 0);
        chk("sb_left", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  rising-edge clock; the single clock.
REQ-003 SHALL have port rst  in  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-004 SHALL have port freeze  in  1  hazard stall; IF/ID holds, so this block holds its outputs.
REQ-005 SHALL have ports branch_taken  in  1 and branch_addr  in  `WORD_LEN: redirect request and target.
REQ-006 SHALL have ports imem_req  out  1 and imem_addr  out  `WORD_LEN: instruction-memory request and word address.
REQ-007 SHALL have ports imem_ack  in  1 and imem_rdata  in  `WORD_LEN: memory response and data, valid when imem_ack=1.
REQ-008 SHALL have ports PC  out  `WORD_LEN and instruction  out  `WORD_LEN: fetched PC+4 and instruction, feeding IF/ID PCIn/instructionIn.
REQ-009 SHALL have ports fetch_valid  out  1 (output pair holds a real instruction) and misalign_err  out  1 (sticky).

Function
REQ-010 SHALL hold internal fetch pointer pc_q; imem_addr=pc_q at all times except in DRAIN.
REQ-011 SHALL keep imem_req high and imem_addr stable from assertion until the cycle imem_ack=1.
REQ-012 SHALL implement FSM states FETCH, HOLD, DRAIN.
REQ-013 In FETCH: imem_req=1; on imem_ack with freeze=0 and branch_taken=0, SHALL register instruction<=imem_rdata, PC<=pc_q+4, fetch_valid<=1, pc_q<=pc_q+4 (one-cycle latency ack->output).
REQ-014 In FETCH with freeze=0, no ack, no branch: SHALL register bubble: instruction<=0, PC<=0, fetch_valid<=0.
REQ-015 In FETCH, ack with freeze=1: SHALL latch rdata and pc_q+4 into skid buffer, advance pc_q, go HOLD; outputs unchanged.
REQ-016 In HOLD: imem_req=0; while freeze=1 SHALL keep outputs and buffer; when freeze=0 SHALL move buffer to outputs with fetch_valid=1, go FETCH.
REQ-017 freeze=1 with no ack SHALL leave outputs unchanged; the pending request continues.
REQ-018 branch_taken=1 SHALL take priority over freeze and ack in every state: pc_q<=branch_addr, skid buffer discarded, outputs<=bubble next cycle.
REQ-019 branch_taken while a request is outstanding without ack SHALL go DRAIN: imem_req held at old address until ack, data dropped, then FETCH at branch target with no bubble cycle lost beyond the drain.
REQ-020 branch_taken in the same cycle as imem_ack SHALL drop that data and stay FETCH at branch_addr.
REQ-021 A second branch_taken during DRAIN SHALL overwrite the pending target; last target wins.
REQ-022 pc_q+4 SHALL wrap modulo 2^32 without flag.

Reset
REQ-023 With rst=0 at clk edge: pc_q=RESET_PC, state=FETCH, PC=0, instruction=0, fetch_valid=0, misalign_err=0, skid buffer empty; imem_req=0 while rst=0.
REQ-024 Reset mid-request SHALL abandon it; any ack in the first cycle after reset release for an address not issued since release SHALL be ignored only if issued before reset (DRAIN not entered).

Configuration
REQ-025 Macro IF_MISALIGN_CHK_EN defined: branch_addr[1:0]!=0 SHALL force pc_q={branch_addr[31:2],2'b00} and set misalign_err until reset.
REQ-026 Macro undefined: branch_addr used unmodified; misalign_err tied 0.

Structure
REQ-027 FSM state encodings and `WORD_LEN SHALL live in shared defines.v; RESET_PC stays a module parameter.
REQ-028 Skid buffer (data+PC, valid bit, load/flush) SHALL be one sub-module, if_skid_buf; remainder inline.

Verification
REQ-029 Reset release, memory acks every cycle with rdata=addr^32'hA5A5_A5A5 -> outputs PC=4,8,12 with matching instruction, fetch_valid=1 each cycle.
REQ-030 freeze=1 for 3 cycles while ack at pc_q=8 -> outputs hold PC=8 pair, then PC=12/data(8) appears first cycle after freeze drops, no instruction lost or duplicated.
REQ-031 branch_taken to 32'h100 with request to 0x10 unacked, ack 2 cycles later -> 0x10 data dropped, next imem_addr=0x100, output PC=0x104.
REQ-032 branch_taken and freeze and ack same cycle -> next fetch 0x100, bubble outputs, fetch_valid=0.
REQ-033 With IF_MISALIGN_CHK_EN, branch to 32'h102 -> imem_addr=0x100, misalign_err=1 until rst=0; without macro imem_addr=0x102, misalign_err=0.
REQ-034 rst=0 asserted mid-HOLD -> all outputs 0, imem_req=0, first post-reset imem_addr=RESET_PC.
